// File: rtl/keypad_scanner.sv
`default_nettype none
// ==== keypad_scanner : 4x4 active-low matrix scanner, frame debounce, 4-deep key FIFO, iomem slave ====
// ==== rev 1.0                                                                                      ====
module keypad_scanner #(
  parameter int SCAN_DIV        = 16000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  COL,
  input  logic [3:0]  ROW,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        key_irq
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_LOAD  = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(DEBOUNCE_FRAMES);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_FRAMES - 1);

  logic          enable_q, enable_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    col_q, col_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   prev_q, prev_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   image_q, image_d;
  logic [3:0]    fifo_q [4];
  logic [3:0]    fifo_d [4];
  logic [1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          sel, is_read, rd_status, ctrl_wr, flush, pop;
  logic          push_req, push_ok;
  logic [3:0]    push_code, head;
  logic [15:0]   edges;
  logic          unused_bits;

  assign unused_bits = ^{iomem_addr[23:4], iomem_wdata[31:2]};

  always_comb begin
    enable_d  = enable_q;
    presc_d   = presc_q;
    col_d     = col_q;
    snap_d    = snap_q;
    prev_d    = prev_q;
    stable_d  = stable_q;
    image_d   = image_q;
    fifo_d    = fifo_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    ready_d   = 1'b0;
    rdata_d   = '0;
    push_req  = 1'b0;
    push_code = '0;
    edges     = '0;

    sel       = iomem_valid && !ready_q && (iomem_addr[31:24] == 8'h05);
    is_read   = (iomem_wstrb == 4'b0000);
    rd_status = sel && is_read && (iomem_addr[3:0] == 4'h0);
    ctrl_wr   = sel && !is_read && (iomem_addr[3:0] == 4'h4) && iomem_wstrb[0];
    flush     = ctrl_wr && iomem_wdata[1];
    pop       = rd_status && (count_q != 3'd0);
    head      = (count_q != 3'd0) ? fifo_q[rd_ptr_q] : 4'h0;

    if (sel) begin
      ready_d = 1'b1;
      if (rd_status)
        rdata_d = {23'b0, ovf_q, count_q, count_q != 3'd0, head};
      else if (is_read && (iomem_addr[3:0] == 4'h4))
        rdata_d = {31'b0, enable_q};
    end
    if (ctrl_wr)
      enable_d = iomem_wdata[0];

    // Scan state is parked at its reset values whenever scanning is off.
    if (!enable_q) begin
      presc_d  = PRESC_LOAD;
      col_d    = 2'd0;
      snap_d   = '0;
      prev_d   = '0;
      stable_d = '0;
    end else if (presc_q != '0) begin
      presc_d = presc_q - PW'(1);
    end else begin
      presc_d = PRESC_LOAD;
      col_d   = col_q + 2'd1;
      snap_d[{col_q, 2'b00} +: 4] = ~ROW;
      if (col_q == 2'd3) begin
        prev_d = snap_d;
        if (snap_d == prev_q) begin
          if (stable_q != STABLE_MAX) begin
            stable_d = stable_q + SW'(1);
            if (stable_q == STABLE_LAST) begin
              image_d = snap_d;
              edges   = snap_d & ~image_q;
            end
          end
        end else begin
          stable_d = '0;
        end
        push_req = |edges;
        // Descending walk leaves the lowest-index press edge as the code.
        for (int i = 15; i >= 0; i--)
          if (edges[i]) push_code = 4'(i);
      end
    end

    push_ok = push_req && ((count_q != 3'd4) || pop);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = 3'd0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) begin
        fifo_d[wr_ptr_q] = push_code;
        wr_ptr_d         = wr_ptr_q + 2'd1;
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
      if (rd_status)
        ovf_d = 1'b0;
      if (push_req && !push_ok)
        ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      presc_q  <= PRESC_LOAD;
      col_q    <= 2'd0;
      snap_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      image_q  <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      enable_q <= enable_d;
      presc_q  <= presc_d;
      col_q    <= col_d;
      snap_q   <= snap_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      image_q  <= image_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
    end
  end

  assign COL         = enable_q ? ~(4'b0001 << col_q) : 4'b1111;
  assign key_irq     = enable_q && (count_q != 3'd0);
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16000: clk cycles per column step (1 ms at 16 MHz).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4: consecutive identical full frames needed to accept a key image.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port COL  output  4  column drives, active-low, one-hot low while enabled.
REQ-006 SHALL have port ROW  input  4  row sense, active-low (pulled up externally).
REQ-007 SHALL have port iomem_valid  input  1  bus request valid.
REQ-008 SHALL have port iomem_ready  output  1  one-cycle bus acknowledge.
REQ-009 SHALL have port iomem_wstrb  input  4  byte write strobes; all zero means read.
REQ-010 SHALL have port iomem_addr  input  32  bus address; selected when [31:24]==8'h05.
REQ-011 SHALL have port iomem_wdata  input  32  write data.
REQ-012 SHALL have port iomem_rdata  output  32  read data, valid when iomem_ready is high.
REQ-013 SHALL have port key_irq  output  1  high while enabled and FIFO non-empty.

Function
REQ-014 Scan SHALL use a prescaler counting SCAN_DIV-1 down to 0; the cycle it reaches 0 is a tick, and it then reloads.
REQ-015 Each tick SHALL sample ~ROW into snapshot bits [col*4+3:col*4] for the column currently driven, then advance col 0->1->2->3->0.
REQ-016 COL SHALL be ~(4'b0001<<col) while enabled and 4'b1111 while disabled.
REQ-017 A frame SHALL complete on the tick that samples col 3; the 16-bit snapshot is then compared with the previous frame.
REQ-018 On a frame with an equal snapshot the stable counter SHALL increment, saturating at DEBOUNCE_FRAMES; on an unequal snapshot it SHALL clear to 0.
REQ-019 On the frame the counter first reaches DEBOUNCE_FRAMES, the debounced image SHALL load the snapshot.
REQ-020 Press edges are the bits set in the new debounced image but not in the old; the lowest-index edge SHALL be pushed as code = col*4+row. Other simultaneous edges SHALL be dropped.
REQ-021 Releases SHALL update the image and SHALL push nothing.
REQ-022 The FIFO SHALL be 4 deep with a 0..4 count.
REQ-023 A push while full SHALL be discarded and SHALL set the sticky overflow flag, unless a pop happens in the same cycle, in which case the push SHALL be accepted.
REQ-024 A simultaneous push and pop SHALL leave the count unchanged.
REQ-025 The bus SHALL respond when iomem_valid && !iomem_ready && addr[31:24]==8'h05: iomem_ready goes high the next cycle for exactly 1 cycle, with iomem_rdata updated in the same cycle.
REQ-026 A read at offset 0x0 (addr[3:0]) SHALL return [3:0] head code, [4] non-empty, [7:5] count, [8] overflow, others 0.
REQ-027 The same read SHALL pop the head if non-empty and SHALL clear overflow.
REQ-028 A read at offset 0x4 SHALL return {31'b0, enable}.
REQ-029 A write at 0x4 with wstrb[0] SHALL set enable = wdata[0].
REQ-030 A write at 0x4 with wstrb[0] and wdata[1] SHALL empty the FIFO and clear overflow; the flush bit is not stored.
REQ-031 Writes to offset 0x0 and any access to other offsets SHALL be acknowledged with rdata 0 and no side effects.
REQ-032 Disabling SHALL hold the prescaler, col, snapshot and stable counter at their reset values, keep the debounced image and FIFO, and force key_irq low.

Reset
REQ-033 On reset the following SHALL take effect: enable=0, COL=4'b1111, col=0, prescaler=SCAN_DIV-1, snapshot/image/stable counter=0, FIFO empty, overflow=0, iomem_ready=0, iomem_rdata=0, key_irq=0.
REQ-034 Reset asserted mid-transaction or mid-frame SHALL abort the transaction and frame with no acknowledge; reset SHALL take priority over all other events.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=2)
REQ-035 After reset, write 0x1 to 0x05000004, hold ROW[2] low only while COL[1] is low, for 4 frames -> read 0x05000000 returns 0x36 (code 6, valid, count 1), key_irq then drops.
REQ-036 A key glitch present for 1 frame only -> no push; count stays 0.
REQ-037 Six distinct presses with no reads -> status returns count 4 and overflow=1, first code read is the first key pressed; after 4 reads status = 0x000.
REQ-038 Keys 3 and 9 stabilize in the same frame -> exactly one entry, code 3.
REQ-039 With 2 entries queued, a push and a status read in the same cycle -> count remains 2 and pop order is preserved.
REQ-040 Write 0x3 to offset 0x4 with 3 entries queued -> next status read = 0x000, key_irq=0, enable read-back = 1.
